// File: rtl/dcache_controller.sv
// Direct-mapped write-through no-write-allocate data cache for the MEM stage (DCACHE_STATS_EN adds hit/miss counters).
// Latency: read hit in 0 cycles; read miss retires the cycle after mem_ack; a store retires in DONE, one cycle after mem_ack.
// Backpressure: hit=0 stalls the pipeline, and mem_req is held with stable addr/we/wdata until mem_ack.
module dcache_controller #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = 32 - 2 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t nextState;

    logic [LINES-1:0]    validBits;
    logic [TAG_BITS-1:0] tagArr  [LINES];
    logic [31:0]         dataArr [LINES];

    logic [INDEX_BITS-1:0] reqIdx;
    logic [TAG_BITS-1:0]   reqTag;
    logic [INDEX_BITS-1:0] fillIdx;
    logic [TAG_BITS-1:0]   fillTag;
    logic                  lineHit;
    logic                  fillHit;
    logic                  readReq;
    logic                  writeReq;
    logic                  issueReq;
    logic                  fillDone;
    logic                  storeDone;
    logic                  unusedAddrBits;

    // Lookup on the live request; fill/store use the latched memory address,
    // which is the same line because the pipeline holds its request while stalled.
    assign reqIdx   = address[INDEX_BITS+1:2];
    assign reqTag   = address[31:INDEX_BITS+2];
    assign fillIdx  = mem_addr[INDEX_BITS+1:2];
    assign fillTag  = mem_addr[31:INDEX_BITS+2];
    assign lineHit  = validBits[reqIdx] && (tagArr[reqIdx] == reqTag);
    assign fillHit  = validBits[fillIdx] && (tagArr[fillIdx] == fillTag);

    // A simultaneous read and write is handled as a store.
    assign writeReq = MemWrite;
    assign readReq  = MemRead && !MemWrite;

    assign issueReq  = (state == IDLE) && (writeReq || (readReq && !lineHit));
    assign fillDone  = (state == MISS) && mem_ack;
    assign storeDone = (state == WRITE) && mem_ack;

    // Byte offset has no meaning for a word cache.
    assign unusedAddrBits = ^address[1:0];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (writeReq) begin
                    nextState = WRITE;
                end else if (readReq && !lineHit) begin
                    nextState = MISS;
                end
            end
            MISS: begin
                if (mem_ack) begin
                    nextState = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Pipeline-facing outputs: hit releases the stall, readData only on a read hit.
    always_comb begin
        hit      = 1'b0;
        readData = '0;
        case (state)
            IDLE: begin
                if (writeReq) begin
                    hit = 1'b0;
                end else if (readReq) begin
                    hit = lineHit;
                    if (lineHit) begin
                        readData = dataArr[reqIdx];
                    end
                end else begin
                    hit = 1'b1;
                end
            end
            DONE:    hit = 1'b1;
            default: hit = 1'b0;
        endcase
    end

    // Memory request: captured only when leaving IDLE, dropped on the completing ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issueReq) begin
            mem_req  <= 1'b1;
            mem_we   <= writeReq;
            mem_addr <= {address[31:2], 2'b00};
            if (writeReq) begin
                mem_wdata <= writeData;
            end
        end else if (fillDone || storeDone) begin
            mem_req <= 1'b0;
        end
    end

    // Valid bits are the only cache state cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validBits <= '0;
        end else if (fillDone) begin
            validBits[fillIdx] <= 1'b1;
        end
    end

    // Tag/data arrays: a fill replaces the line outright; a store updates only a resident line.
    always_ff @(posedge clk) begin
        if (fillDone) begin
            tagArr[fillIdx]  <= fillTag;
            dataArr[fillIdx] <= mem_rdata;
        end else if (storeDone && fillHit) begin
            dataArr[fillIdx] <= mem_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    // Read hits retired in IDLE, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if ((state == IDLE) && readReq && lineHit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
        end
    end

    // Read misses counted on the IDLE->MISS step, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= '0;
        end else if (issueReq && readReq && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
